// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and sizes for the UART word receiver
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    localparam int DATA_BITS      = 8;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_word_rx_if.sv
// rtl/uart_word_rx_if.sv - word stream handshake between receiver and consumer
interface uart_word_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS*BYTES_PER_WORD-1:0] tdata;
    logic                                tvalid;
    logic                                tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver: rx synchroniser, bit FSM and baud counter
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_rx,
    input  logic                 i_flush,
    output logic [DATA_BITS-1:0] o_byte,
    output logic                 o_byte_done,
    output logic                 o_frame_err,
    output logic                 o_idle
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

    uart_rx_state_t       r_state;
    logic                 r_rx_meta;
    logic                 r_rxs;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;

    logic w_bit_end;
    logic w_stop_sample;

    assign w_bit_end     = (r_cnt == BIT_LAST);
    assign w_stop_sample = (r_state == STOP) && w_bit_end;

    // Done/error are decoded straight from the stop sample so the word
    // register in the top can capture on that same edge.
    assign o_byte      = r_shift;
    assign o_byte_done = w_stop_sample && r_rxs;
    assign o_frame_err = w_stop_sample && !r_rxs;
    assign o_idle      = (r_state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_rx_meta <= i_rx;
            r_rxs     <= r_rx_meta;
            if (i_flush) begin
                r_state   <= IDLE;
                r_cnt     <= '0;
                r_bit_idx <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        if (!r_rxs) r_state <= START;
                    end
                    START: begin
                        if (r_cnt == HALF_LAST) begin
                            r_cnt   <= '0;
                            r_state <= r_rxs ? IDLE : DATA;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (w_bit_end) begin
                            r_cnt     <= '0;
                            r_shift   <= {r_rxs, r_shift[DATA_BITS-1:1]};
                            r_bit_idx <= r_bit_idx + 1'b1;
                            if (r_bit_idx == IDX_LAST) r_state <= STOP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (w_bit_end) begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_word_rx.sv
// rtl/uart_word_rx.sv - packs four received bytes into a 32-bit word with timeout and overrun flags
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int TIMEOUT_CLKS = CLKS_PER_BIT * 40
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_rx,
    input  logic           i_flush,
    uart_word_rx_if.master m_word,
    output logic           o_busy,
    output logic           o_frame_err,
    output logic           o_timeout_err,
    output logic           o_overrun_err
);

    localparam int WW   = DATA_BITS * BYTES_PER_WORD;
    localparam int SW   = DATA_BITS * (BYTES_PER_WORD - 1);
    localparam int NW   = $clog2(BYTES_PER_WORD);
    localparam int TW   = $clog2(TIMEOUT_CLKS);
    localparam logic [NW-1:0] CNT_LAST = NW'(BYTES_PER_WORD - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CLKS - 1);

    logic [DATA_BITS-1:0] w_byte;
    logic                 w_sub_done;
    logic                 w_sub_frame;
    logic                 w_sub_idle;
    logic                 w_byte_done;
    logic                 w_frame;
    logic                 w_last;
    logic                 w_take;
    logic                 w_to_run;

    logic [SW-1:0] r_shift;
    logic [NW-1:0] r_byte_cnt;
    logic [TW-1:0] r_to_cnt;
    logic [WW-1:0] r_word;
    logic          r_valid;
    logic          r_frame_err;
    logic          r_timeout_err;
    logic          r_overrun_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rx       (i_rx),
        .i_flush    (i_flush),
        .o_byte     (w_byte),
        .o_byte_done(w_sub_done),
        .o_frame_err(w_sub_frame),
        .o_idle     (w_sub_idle)
    );

    // flush overrides anything the byte receiver reports in the same cycle
    assign w_byte_done = w_sub_done && !i_flush;
    assign w_frame     = w_sub_frame && !i_flush;
    assign w_last      = w_byte_done && (r_byte_cnt == CNT_LAST);
    assign w_take      = r_valid && m_word.tready;
    assign w_to_run    = (r_byte_cnt != '0) && w_sub_idle;

    assign m_word.tdata  = r_word;
    assign m_word.tvalid = r_valid;
    assign o_busy        = !w_sub_idle || (r_byte_cnt != '0);
    assign o_frame_err   = r_frame_err;
    assign o_timeout_err = r_timeout_err;
    assign o_overrun_err = r_overrun_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift       <= '0;
            r_byte_cnt    <= '0;
            r_to_cnt      <= '0;
            r_word        <= '0;
            r_valid       <= 1'b0;
            r_frame_err   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_frame_err   <= w_frame;
            r_timeout_err <= 1'b0;
            r_overrun_err <= 1'b0;

            // Earlier bytes shift down so byte0 ends up in the low lane.
            if (i_flush || w_frame) begin
                r_byte_cnt <= '0;
                r_to_cnt   <= '0;
            end else if (w_byte_done) begin
                r_shift    <= {w_byte, r_shift[SW-1:DATA_BITS]};
                r_byte_cnt <= r_byte_cnt + 1'b1;
                r_to_cnt   <= '0;
            end else if (w_to_run) begin
                if (r_to_cnt == TO_LAST) begin
                    r_byte_cnt    <= '0;
                    r_to_cnt      <= '0;
                    r_timeout_err <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end

            if (w_last) begin
                r_word  <= {w_byte, r_shift};
                r_valid <= 1'b1;
                if (r_valid && !m_word.tready) r_overrun_err <= 1'b1;
            end else if (w_take) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
